tedv4_onchip_memory: RTL and testbench

Parametrised on-chip memory slave for the TED processor system, the generation after the fixed 45000×32 single-port instruction store. Width, depth and read latency are set by parameters. It adds a pipelined Avalon-MM read path with `readdatavalid`, and `waitrequest` back-pressure. It also has an optional post-reset clear sequence, out-of-range access handling, and a compile-time write-protect window. It sits on the system interconnect as the instruction or data memory of a TED core.

---
 rtl/tedv4_onchip_memory.sv | 171 +++++++++++++++++
 tb/tb_tedv4_onchip_memory.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tedv4_onchip_memory.sv
// ============================================================================
// Module   : tedv4_onchip_memory
// Purpose  : Parametrised Avalon-MM on-chip memory slave with pipelined reads,
//            optional post-reset clear, and a write-protect window that is
//            compiled in by defining TED_MEM_WRITE_PROTECT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tedv4_onchip_memory #(
   parameter int DATA_W         = 32,
   parameter int DEPTH          = 45000,
   parameter int ADDR_W         = 16,
   parameter int READ_LATENCY   = 1,
   parameter int CLEAR_ON_RESET = 0,
   parameter int PROT_LIMIT     = 0
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                chipselect,
   input  logic                read,
   input  logic                write,
   input  logic [ADDR_W-1:0]   address,
   input  logic [DATA_W/8-1:0] byteenable,
   input  logic [DATA_W-1:0]   writedata,
   output logic [DATA_W-1:0]   readdata,
   output logic                readdatavalid,
   output logic                waitrequest,
   output logic                init_done,
   output logic                wr_err
);

   localparam int              c_nbytes = DATA_W / 8;
   localparam int              c_idx_w  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_W:0] c_depth  = (ADDR_W + 1)'(DEPTH);
   localparam logic [c_idx_w-1:0] c_last = c_idx_w'(DEPTH - 1);

   typedef enum logic [0:0] {
      S_CLEAR = 1'b0,
      S_READY = 1'b1
   } state_t;

   state_t               state_q;
   logic [c_idx_w-1:0]   clr_addr_q;
   logic                 waitrequest_q;
   logic                 init_done_q;
   logic                 wr_err_q;

   logic [DATA_W-1:0]    mem [DEPTH];
   logic                 rvalid1_q;
   logic [DATA_W-1:0]    rdata1_q;

   logic                 w_wr_acc;
   logic                 w_rd_acc;
   logic                 w_in_range;
   logic                 w_prot;
   logic [c_idx_w-1:0]   w_idx;
   logic                 w_we;
   logic [c_idx_w-1:0]   w_waddr;
   logic [DATA_W-1:0]    w_wdata;
   logic [c_nbytes-1:0]  w_wbe;

   // A simultaneous read+write is treated as a write only.
   assign w_wr_acc   = chipselect & write & ~waitrequest_q;
   assign w_rd_acc   = chipselect & read & ~write & ~waitrequest_q;
   assign w_in_range = ({1'b0, address} < c_depth);
   assign w_idx      = address[c_idx_w-1:0];

`ifdef TED_MEM_WRITE_PROTECT_EN
   localparam logic [ADDR_W:0] c_prot = (ADDR_W + 1)'(PROT_LIMIT);
   assign w_prot = ({1'b0, address} < c_prot);
`else
   logic w_unused_prot;
   assign w_unused_prot = ^PROT_LIMIT;
   assign w_prot        = 1'b0;
`endif

   // The clear sequence owns the single write port while it runs.
   always_comb begin
      w_we    = 1'b0;
      w_waddr = w_idx;
      w_wdata = writedata;
      w_wbe   = byteenable;
      if (state_q == S_CLEAR) begin
         w_we    = 1'b1;
         w_waddr = clr_addr_q;
         w_wdata = '0;
         w_wbe   = '1;
      end else if (w_wr_acc && w_in_range && !w_prot) begin
         w_we = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (w_we) begin
         for (int i = 0; i < c_nbytes; i++) begin
            if (w_wbe[i]) begin
               mem[w_waddr][i*8 +: 8] <= w_wdata[i*8 +: 8];
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_READY;
         clr_addr_q    <= '0;
         waitrequest_q <= (CLEAR_ON_RESET != 0);
         init_done_q   <= (CLEAR_ON_RESET == 0);
         wr_err_q      <= 1'b0;
      end else begin
         case (state_q)
            S_CLEAR: begin
               if (clr_addr_q == c_last) begin
                  state_q       <= S_READY;
                  waitrequest_q <= 1'b0;
                  init_done_q   <= 1'b1;
               end else begin
                  clr_addr_q <= clr_addr_q + c_idx_w'(1);
               end
            end
            S_READY: begin
               if (w_wr_acc && w_prot) begin
                  wr_err_q <= 1'b1;
               end
            end
            default: state_q <= S_READY;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rvalid1_q <= 1'b0;
         rdata1_q  <= '0;
      end else begin
         rvalid1_q <= w_rd_acc;
         if (w_rd_acc) begin
            rdata1_q <= w_in_range ? mem[w_idx] : '0;
         end
      end
   end

   generate
      if (READ_LATENCY == 2) begin : g_lat2
         logic              rvalid2_q;
         logic [DATA_W-1:0] rdata2_q;
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               rvalid2_q <= 1'b0;
               rdata2_q  <= '0;
            end else begin
               rvalid2_q <= rvalid1_q;
               rdata2_q  <= rdata1_q;
            end
         end
         assign readdata      = rdata2_q;
         assign readdatavalid = rvalid2_q;
      end else begin : g_lat1
         assign readdata      = rdata1_q;
         assign readdatavalid = rvalid1_q;
      end
   endgenerate

   assign waitrequest = waitrequest_q;
   assign init_done   = init_done_q;
   assign wr_err      = wr_err_q;

endmodule

`default_nettype wire

// File: tb/tb_tedv4_onchip_memory.sv
// ============================================================================
// Module   : tb_tedv4_onchip_memory
// Purpose  : Scoreboard bench for tedv4_onchip_memory: a small-depth clearing
//            instance (latency 2) and a full-depth instance (latency 1).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tedv4_onchip_memory;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst = 1'b1;
   logic        cs [2];
   logic        rd [2];
   logic        wr [2];
   logic [15:0] ad [2];
   logic [3:0]  be [2];
   logic [31:0] wd [2];
   logic [31:0] rdata [2];
   logic        rvalid [2];
   logic        wreq [2];
   logic        idone [2];
   logic        werr [2];

   tedv4_onchip_memory #(
      .DATA_W(32), .DEPTH(16), .ADDR_W(8), .READ_LATENCY(2),
      .CLEAR_ON_RESET(1), .PROT_LIMIT(4)
   ) u_a (
      .clk(clk), .reset(rst), .chipselect(cs[0]), .read(rd[0]), .write(wr[0]),
      .address(ad[0][7:0]), .byteenable(be[0]), .writedata(wd[0]),
      .readdata(rdata[0]), .readdatavalid(rvalid[0]), .waitrequest(wreq[0]),
      .init_done(idone[0]), .wr_err(werr[0])
   );

   tedv4_onchip_memory #(
      .DATA_W(32), .DEPTH(45000), .ADDR_W(16), .READ_LATENCY(1),
      .CLEAR_ON_RESET(0), .PROT_LIMIT(4)
   ) u_b (
      .clk(clk), .reset(rst), .chipselect(cs[1]), .read(rd[1]), .write(wr[1]),
      .address(ad[1]), .byteenable(be[1]), .writedata(wd[1]),
      .readdata(rdata[1]), .readdatavalid(rvalid[1]), .waitrequest(wreq[1]),
      .init_done(idone[1]), .wr_err(werr[1])
   );

   typedef struct packed {
      logic [31:0] data;
      logic        known;
      int          cyc;
   } exp_t;

   int          n_tests = 0;
   int          n_fail  = 0;
   int          cyc     = 0;
   exp_t        q0 [$];
   exp_t        q1 [$];
   logic [31:0] mdl_a [16];
   logic [31:0] mdl_b [int];
   bit          werr_exp [2];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Reference: memory contents as arrays, responses as a FIFO of expected
   // (data, arrival cycle) pairs.
   function automatic void acc(input int d, input bit r, input bit w,
                               input logic [15:0] a, input logic [3:0] b,
                               input logic [31:0] dat);
      bit          inr;
      bit          prot;
      logic [31:0] val;
      exp_t        e;
      inr = (d == 0) ? (a < 16) : (a < 45000);
`ifdef TED_MEM_WRITE_PROTECT_EN
      prot = (a < 4);
`else
      prot = 1'b0;
`endif
      val = 32'hxxxxxxxx;
      if (inr) begin
         if (d == 0) val = mdl_a[a[3:0]];
         else if (mdl_b.exists(int'(a))) val = mdl_b[int'(a)];
      end
      if (w) begin
         if (prot) begin
            werr_exp[d] = 1'b1;
         end else if (inr) begin
            for (int i = 0; i < 4; i++) if (b[i]) val[i*8 +: 8] = dat[i*8 +: 8];
            if (d == 0) mdl_a[a[3:0]] = val;
            else mdl_b[int'(a)] = val;
         end
      end else if (r) begin
         e.data  = inr ? val : 32'h0;
         e.known = !$isunknown(e.data);
         e.cyc   = cyc + ((d == 0) ? 2 : 1);
         if (d == 0) q0.push_back(e);
         else q1.push_back(e);
      end
   endfunction

   task automatic mon(input int d);
      exp_t e;
      bit   empty;
      if (rvalid[d] !== 1'b1) return;
      empty = (d == 0) ? (q0.size() == 0) : (q1.size() == 0);
      if (empty) begin
         chk($sformatf("unexpected_rdvalid_%0d", d), 32'd1, 32'd0);
         return;
      end
      e = (d == 0) ? q0.pop_front() : q1.pop_front();
      chk($sformatf("read_cycle_%0d", d), cyc, e.cyc);
      if (e.known) chk($sformatf("read_data_%0d", d), rdata[d], e.data);
   endtask

   always @(negedge clk) begin
      mon(0);
      mon(1);
   end

   task automatic idle_all();
      for (int d = 0; d < 2; d++) begin
         cs[d] = 1'b0; rd[d] = 1'b0; wr[d] = 1'b0;
      end
   endtask

   task automatic idle(input int n);
      @(negedge clk);
      idle_all();
      repeat (n - 1) @(negedge clk);
   endtask

   task automatic cmd(input int d, input bit r, input bit w, input bit c,
                      input logic [15:0] a, input logic [3:0] b, input logic [31:0] dat);
      int guard;
      @(negedge clk);
      idle_all();
      cs[d] = c; rd[d] = r; wr[d] = w; ad[d] = a; be[d] = b; wd[d] = dat;
      guard = 0;
      while (wreq[d] === 1'b1 && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 100) begin
         chk("cmd_wait_timeout", 32'd1, 32'd0);
         return;
      end
      if (c && (r || w)) acc(d, r, w, a, b, dat);
   endtask

   task automatic do_reset(input int hold);
      @(negedge clk);
      #2 rst = 1'b1;
      idle_all();
      q0.delete();
      q1.delete();
      werr_exp[0] = 1'b0;
      werr_exp[1] = 1'b0;
      #1;
      chk("rst_rdvalid_a", rvalid[0], 1'b0);
      chk("rst_rdata_a",   rdata[0],  32'h0);
      chk("rst_wrerr_a",   werr[0],   1'b0);
      chk("rst_wreq_a",    wreq[0],   1'b1);
      chk("rst_idone_a",   idone[0],  1'b0);
      chk("rst_rdvalid_b", rvalid[1], 1'b0);
      chk("rst_rdata_b",   rdata[1],  32'h0);
      chk("rst_wreq_b",    wreq[1],   1'b0);
      chk("rst_idone_b",   idone[1],  1'b1);
      repeat (hold) @(negedge clk);
      #2 rst = 1'b0;
   endtask

   task automatic wait_clear();
      int n;
      int early;
      n = 0;
      early = 0;
      while (n < 100) begin
         @(negedge clk);
         n++;
         if (wreq[0] === 1'b0) break;
         if (idone[0] !== 1'b0) early++;
      end
      chk("clear_cycles",   n, 16);
      chk("init_done_rise", idone[0], 1'b1);
      chk("init_done_early", early, 0);
      for (int i = 0; i < 16; i++) mdl_a[i] = 32'h0;
   endtask

   function automatic logic [15:0] b_addr(input int r);
      if (r < 8)  return 16'(8 + r);
      if (r < 16) return 16'(44984 + r);
      if (r < 24) return 16'(45000 + r - 16);
      return 16'hFFFF;
   endfunction

   task automatic rand_ops(input int d, input int n);
      for (int i = 0; i < n; i++) begin
         int          op;
         bit          c;
         logic [15:0] a;
         op = int'($urandom_range(0, 9));
         c  = ($urandom_range(0, 9) != 0);
         a  = (d == 0) ? 16'($urandom_range(0, 19)) : b_addr(int'($urandom_range(0, 24)));
         cmd(d, (op < 5) || (op == 9), (op >= 5), c, a, 4'($urandom), $urandom);
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      idle_all();
      for (int d = 0; d < 2; d++) begin
         ad[d] = '0; be[d] = '0; wd[d] = '0; werr_exp[d] = 1'b0;
      end

      do_reset(3);
      wait_clear();
      for (int a = 0; a < 16; a++) cmd(0, 1, 0, 1, 16'(a), 4'h0, 32'h0);

      cmd(0, 0, 1, 1, 16'd5, 4'hF, 32'hAABBCCDD);
      cmd(0, 0, 1, 1, 16'd5, 4'h5, 32'h11223344);
      cmd(0, 1, 0, 1, 16'd5, 4'h0, 32'h0);
      for (int a = 1; a < 4; a++) cmd(0, 0, 1, 1, 16'(a + 8), 4'hF, 32'h1000 + 32'(a));
      for (int a = 1; a < 4; a++) cmd(0, 1, 0, 1, 16'(a + 8), 4'h0, 32'h0);
      for (int a = 1; a < 4; a++) cmd(0, 1, 0, 1, 16'(a), 4'h0, 32'h0);
      cmd(0, 1, 1, 1, 16'd6, 4'hF, 32'h66666666);
      cmd(0, 1, 0, 1, 16'd6, 4'h0, 32'h0);

      for (int a = 0; a < 16; a++) cmd(1, 0, 1, 1, b_addr(a), 4'hF, $urandom);
      cmd(1, 0, 1, 1, 16'd45000, 4'hF, 32'hDEADBEEF);
      cmd(1, 1, 0, 1, 16'd45000, 4'h0, 32'h0);
      cmd(1, 1, 0, 1, 16'd44999, 4'h0, 32'h0);
      cmd(1, 1, 0, 1, 16'hFFFF, 4'h0, 32'h0);

      cmd(0, 0, 1, 1, 16'd2, 4'hF, 32'h12345678);
      idle(1);
      chk("wr_err_after_prot", werr[0], werr_exp[0]);
      cmd(0, 1, 0, 1, 16'd2, 4'h0, 32'h0);
      cmd(0, 0, 1, 1, 16'd4, 4'hF, 32'h44444444);
      cmd(0, 1, 0, 1, 16'd4, 4'h0, 32'h0);
      idle(3);
      chk("wr_err_held", werr[0], werr_exp[0]);

      rand_ops(0, 400);
      rand_ops(1, 400);
      idle(3);
      chk("wr_err_rand_a", werr[0], werr_exp[0]);
      chk("wr_err_rand_b", werr[1], werr_exp[1]);

      cmd(0, 1, 0, 1, 16'd3, 4'h0, 32'h0);
      do_reset(2);
      repeat (5) @(negedge clk);
      do_reset(2);
      wait_clear();
      for (int a = 0; a < 16; a++) cmd(0, 1, 0, 1, 16'(a), 4'h0, 32'h0);
      cmd(1, 1, 0, 1, 16'd45000, 4'h0, 32'h0);
      cmd(1, 1, 0, 1, 16'd44999, 4'h0, 32'h0);

      idle(6);
      chk("drain_a", q0.size(), 0);
      chk("drain_b", q1.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
